// File: rtl/wb_mem_arbiter.sv
// Round-robin Wishbone B3 arbiter sharing one slave between NM masters.
// Grant is held for a whole cycle (bursts included); a watchdog aborts stalled accesses.
module wb_mem_arbiter #(
   parameter int NM      = 3,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 256
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_n_i,
   input  logic [NM*AW-1:0]     m_adr_i,
   input  logic [NM*DW-1:0]     m_dat_i,
   input  logic [NM*DW/8-1:0]   m_sel_i,
   input  logic [NM-1:0]        m_we_i,
   input  logic [NM-1:0]        m_cyc_i,
   input  logic [NM-1:0]        m_stb_i,
   input  logic [NM*3-1:0]      m_cti_i,
   input  logic [NM*2-1:0]      m_bte_i,
   output logic [DW-1:0]        m_dat_o,
   output logic [NM-1:0]        m_ack_o,
   output logic [NM-1:0]        m_err_o,
   output logic [NM-1:0]        m_rty_o,
   output logic [AW-1:0]        s_adr_o,
   output logic [DW-1:0]        s_dat_o,
   output logic [DW/8-1:0]      s_sel_o,
   output logic                 s_we_o,
   output logic                 s_cyc_o,
   output logic                 s_stb_o,
   output logic [2:0]           s_cti_o,
   output logic [1:0]           s_bte_o,
   input  logic [DW-1:0]        s_dat_i,
   input  logic                 s_ack_i,
   input  logic                 s_err_i,
   input  logic                 s_rty_i,
   output logic [NM-1:0]        grant_o,
   output logic                 timeout_o
);

   localparam int SW = DW / 8;
   localparam int IW = (NM > 1) ? $clog2(NM) : 1;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST  = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
   localparam logic [IW-1:0] LAST_INIT = IW'(NM - 1);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      ABORT
   } state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   owner, owner_nxt;
   logic [IW-1:0]   last, last_nxt;
   logic [IW-1:0]   sel, pick;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [NM-1:0]   onehot;
   logic            found, term, fire;
   logic            owner_cyc, cyc_sel, stb_sel, we_sel;
   int unsigned     cand;

   assign term    = s_ack_i | s_err_i | s_rty_i;
   assign m_dat_o = s_dat_i;

   // Slave-side mux: idle and unowned cycles show master 0 with the bus qualifiers forced low.
   always_comb begin
      sel       = (state == IDLE) ? '0 : owner;
      s_adr_o   = '0;
      s_dat_o   = '0;
      s_sel_o   = '0;
      s_cti_o   = '0;
      s_bte_o   = '0;
      cyc_sel   = 1'b0;
      stb_sel   = 1'b0;
      we_sel    = 1'b0;
      owner_cyc = 1'b0;
      onehot    = '0;
      for (int unsigned k = 0; k < NM; k++) begin
         onehot[k] = (owner == IW'(k));
         if (owner == IW'(k))
            owner_cyc = m_cyc_i[k];
         if (sel == IW'(k)) begin
            s_adr_o = m_adr_i[k*AW +: AW];
            s_dat_o = m_dat_i[k*DW +: DW];
            s_sel_o = m_sel_i[k*SW +: SW];
            s_cti_o = m_cti_i[k*3 +: 3];
            s_bte_o = m_bte_i[k*2 +: 2];
            cyc_sel = m_cyc_i[k];
            stb_sel = m_stb_i[k];
            we_sel  = m_we_i[k];
         end
      end
      s_cyc_o = (state == GRANT) & cyc_sel;
      s_stb_o = (state == GRANT) & stb_sel;
      s_we_o  = (state == GRANT) & we_sel;
   end

   always_comb begin
      grant_o   = (state != IDLE) ? onehot : '0;
      m_ack_o   = (state == GRANT && s_ack_i) ? onehot : '0;
      m_rty_o   = (state == GRANT && s_rty_i) ? onehot : '0;
      m_err_o   = ((state == GRANT && s_err_i) || state == ABORT) ? onehot : '0;
      timeout_o = (state == ABORT);
   end

   // A terminating slave in the watchdog's last cycle suppresses the abort.
   assign fire = (TIMEOUT > 0) && (state == GRANT) && s_stb_o && !term && (cnt == CNT_LAST);

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      last_nxt  = last;
      cnt_nxt   = '0;
      found     = 1'b0;
      pick      = last;
      cand      = 0;
      for (int unsigned i = 1; i <= NM; i++) begin
         cand = (32'(last) + i) % NM;
         for (int unsigned k = 0; k < NM; k++) begin
            if (!found && cand == k && m_cyc_i[k]) begin
               found = 1'b1;
               pick  = IW'(k);
            end
         end
      end
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt = GRANT;
               owner_nxt = pick;
            end
         end
         GRANT: begin
            if (!owner_cyc) begin
               state_nxt = IDLE;
               last_nxt  = owner;
            end else if (fire) begin
               state_nxt = ABORT;
            end else if (s_stb_o && !term) begin
               cnt_nxt = (cnt == '1) ? cnt : cnt + 1'b1;
            end
         end
         ABORT: begin
            if (!owner_cyc) begin
               state_nxt = IDLE;
               last_nxt  = owner;
            end else begin
               state_nxt = GRANT;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state <= IDLE;
         owner <= '0;
         last  <= LAST_INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         last  <= last_nxt;
         cnt   <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter: round-robin order, burst hold, watchdog, async reset.
module tb_wb_mem_arbiter;

   localparam int NM = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NM*AW-1:0]    m_adr;
   logic [NM*DW-1:0]    m_dat;
   logic [NM*SW-1:0]    m_sel;
   logic [NM-1:0]       m_we, m_cyc, m_stb;
   logic [NM*3-1:0]     m_cti;
   logic [NM*2-1:0]     m_bte;
   logic [DW-1:0]       m_rdat;
   logic [NM-1:0]       m_ack, m_err, m_rty;
   logic [AW-1:0]       s_adr;
   logic [DW-1:0]       s_wdat;
   logic [SW-1:0]       s_sel;
   logic                s_we, s_cyc, s_stb;
   logic [2:0]          s_cti;
   logic [1:0]          s_bte;
   logic [DW-1:0]       s_rdat;
   logic                s_ack, s_err, s_rty;
   logic [NM-1:0]       grant;
   logic                timeout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_mem_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(16)) dut (
      .wb_clk_i   (clk),
      .wb_rst_n_i (rst_n),
      .m_adr_i    (m_adr),
      .m_dat_i    (m_dat),
      .m_sel_i    (m_sel),
      .m_we_i     (m_we),
      .m_cyc_i    (m_cyc),
      .m_stb_i    (m_stb),
      .m_cti_i    (m_cti),
      .m_bte_i    (m_bte),
      .m_dat_o    (m_rdat),
      .m_ack_o    (m_ack),
      .m_err_o    (m_err),
      .m_rty_o    (m_rty),
      .s_adr_o    (s_adr),
      .s_dat_o    (s_wdat),
      .s_sel_o    (s_sel),
      .s_we_o     (s_we),
      .s_cyc_o    (s_cyc),
      .s_stb_o    (s_stb),
      .s_cti_o    (s_cti),
      .s_bte_o    (s_bte),
      .s_dat_i    (s_rdat),
      .s_ack_i    (s_ack),
      .s_err_i    (s_err),
      .s_rty_i    (s_rty),
      .grant_o    (grant),
      .timeout_o  (timeout)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #2;
   endtask

   task automatic req(input int k, input logic on, input logic [AW-1:0] adr,
                      input logic [2:0] cti, input logic [1:0] bte);
      m_cyc[k]             = on;
      m_stb[k]             = on;
      m_we[k]              = 1'b0;
      m_adr[k*AW +: AW]    = adr;
      m_cti[k*3 +: 3]      = cti;
      m_bte[k*2 +: 2]      = bte;
   endtask

   // Current owner k gets one acked beat, drops cyc, then one dead cycle follows.
   task automatic serve(input int k, input logic [NM-1:0] exp);
      check("serve_grant", grant, exp);
      s_ack = 1'b1;
      #1;
      check("serve_ack", m_ack, exp);
      step;
      req(k, 1'b0, '0, 3'b000, 2'b00);
      s_ack = 1'b0;
      #1;
      check("serve_release_cyc", s_cyc, 1'b0);
      step;
      check("serve_gap", grant, '0);
      step;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout got running expected finished");
      $fatal(1);
   end

   initial begin
      logic [2:0] ctis [4];
      ctis = '{3'b010, 3'b010, 3'b010, 3'b111};
      rst_n  = 1'b0;
      m_adr  = '0;
      m_dat  = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
      m_sel  = {4'h3, 4'hC, 4'hF};
      m_we   = '0;
      m_cyc  = '0;
      m_stb  = '0;
      m_cti  = '0;
      m_bte  = '0;
      s_rdat = '0;
      s_ack  = 1'b0;
      s_err  = 1'b0;
      s_rty  = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check("rst_grant", grant, 3'b000);
      check("rst_sbus", {s_cyc, s_stb, s_we}, 3'b000);
      check("rst_term", {m_ack, m_err, m_rty, timeout}, 10'b0);
      rst_n = 1'b1;

      // T1: m1 single read
      req(1, 1'b1, 32'h100, 3'b000, 2'b00);
      #1;
      check("t1_pre_grant", grant, 3'b000);
      step;
      check("t1_grant", grant, 3'b010);
      check("t1_adr", s_adr, 32'h100);
      check("t1_sel", s_sel, 4'hC);
      check("t1_wdat", s_wdat, 32'h1111_1111);
      check("t1_sbus", {s_cyc, s_stb, s_we}, 3'b110);
      s_rdat = 32'hCAFE_0100;
      s_ack  = 1'b1;
      #1;
      check("t1_ack", m_ack, 3'b010);
      check("t1_rdat", m_rdat, 32'hCAFE_0100);
      step;
      req(1, 1'b0, '0, 3'b000, 2'b00);
      s_ack = 1'b0;
      step;
      check("t1_idle", grant, 3'b000);

      // T2: three-way tie right after reset
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      req(0, 1'b1, 32'h10, 3'b000, 2'b00);
      req(1, 1'b1, 32'h14, 3'b000, 2'b00);
      req(2, 1'b1, 32'h18, 3'b000, 2'b00);
      step;
      serve(0, 3'b001);
      serve(1, 3'b010);
      serve(2, 3'b100);

      // T3: m0 burst holds grant while m2 waits
      req(0, 1'b1, 32'h200, 3'b010, 2'b01);
      req(2, 1'b1, 32'h300, 3'b000, 2'b00);
      step;
      check("t3_bte", s_bte, 2'b01);
      for (int b = 0; b < 4; b++) begin
         m_cti[2:0]  = ctis[b];
         m_adr[31:0] = 32'h200 + 32'(4 * b);
         s_ack       = 1'b1;
         #1;
         check("t3_cti", s_cti, ctis[b]);
         check("t3_ack", m_ack, 3'b001);
         step;
      end
      req(0, 1'b0, '0, 3'b000, 2'b00);
      s_ack = 1'b0;
      #1;
      check("t3_hold", grant, 3'b001);
      step;
      check("t3_gap", grant, 3'b000);
      step;
      serve(2, 3'b100);

      // termination on the watchdog's last cycle wins over the abort
      req(0, 1'b1, 32'h400, 3'b000, 2'b00);
      step;
      repeat (15) step;
      s_ack = 1'b1;
      #1;
      check("tw_ack", m_ack, 3'b001);
      check("tw_no_pulse", timeout, 1'b0);
      step;
      s_ack = 1'b0;
      #1;
      check("tw_no_abort", {timeout, m_err, s_cyc}, 5'b0_000_1);
      req(0, 1'b0, '0, 3'b000, 2'b00);
      step;

      // T4: m1 stalls until the watchdog fires
      req(1, 1'b1, 32'h500, 3'b000, 2'b00);
      step;
      check("t4_stb", s_stb, 1'b1);
      for (int i = 0; i < 16; i++) begin
         check("t4_wait", {timeout, m_err, s_cyc}, 5'b0_000_1);
         step;
      end
      check("t4_abort", {timeout, m_err, s_cyc, s_stb}, 6'b1_010_0_0);
      check("t4_abort_grant", grant, 3'b010);
      step;
      check("t4_regrant", {timeout, m_err, s_cyc}, 5'b0_000_1);
      req(1, 1'b0, '0, 3'b000, 2'b00);
      step;
      check("t4_idle", grant, 3'b000);

      // T6: last=1, m0 and m2 tie -> m2 first
      req(0, 1'b1, 32'h600, 3'b000, 2'b00);
      req(2, 1'b1, 32'h700, 3'b000, 2'b00);
      step;
      serve(2, 3'b100);
      serve(0, 3'b001);

      // T5: async reset mid-burst, then m0 wins the tie
      req(2, 1'b1, 32'h800, 3'b010, 2'b00);
      step;
      s_ack = 1'b1;
      step;
      s_ack = 1'b0;
      #1;
      check("t5_beat2", s_cyc, 1'b1);
      rst_n = 1'b0;
      #1;
      check("t5_rst_cyc", s_cyc, 1'b0);
      check("t5_rst_grant", grant, 3'b000);
      req(0, 1'b1, 32'h900, 3'b000, 2'b00);
      #3;
      rst_n = 1'b1;
      step;
      check("t5_tie", grant, 3'b001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
